// File: rtl/chart_sequencer.sv
// rtl/chart_sequencer.sv - step-chart player issuing one-cycle launch pulses to four arrow lanes
//
// Reads chart entries from an external synchronous ROM and paces them with the
// sixteenth-note pulse. Launches into lanes without a free slot are suppressed
// and counted in a saturating counter.
//
// Build option: define CHART_SEQUENCER_LOOP_EN to restart the chart at
// address 0 on the end marker or on address overflow instead of entering DONE.
//
// Ports:
//   clk_i        in   1          system clock
//   reset_i      in   1          asynchronous active-high reset
//   start_i      in   1          one-cycle pulse, starts playback at address 0 (IDLE/DONE only)
//   stop_i       in   1          level, aborts playback back to IDLE
//   pause_i      in   1          level, freezes step counting in WAIT
//   sixteenth_i  in   1          one-cycle pulse per sixteenth note
//   lane_ready_i in   4          per-lane free-slot flags {right, down, up, left}
//   rom_data_i   in   4+DUR_W    entry: [3:0] lane mask, [4+:DUR_W] duration
//   rom_addr_o   out  ADDR_W     chart ROM address
//   rom_rd_o     out  1          ROM read strobe
//   launch_o     out  4          one-cycle launch pulses per lane
//   busy_o       out  1          high in FETCH, DECODE, LAUNCH, WAIT
//   done_o       out  1          high in DONE
//   drop_cnt_o   out  DROP_W     saturating count of suppressed launches

module chart_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DUR_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                pause_i,
  input  logic                sixteenth_i,
  input  logic [3:0]          lane_ready_i,
  input  logic [4+DUR_W-1:0]  rom_data_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  output logic                rom_rd_o,
  output logic [3:0]          launch_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [DROP_W-1:0]   drop_cnt_o
);

`ifdef CHART_SEQUENCER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
  logic [3:0]          r_mask,  w_mask_nxt;
  logic [DUR_W-1:0]    r_dur,   w_dur_nxt;
  logic [DUR_W-1:0]    r_cnt,   w_cnt_nxt;
  logic [DROP_W-1:0]   r_drop,  w_drop_nxt;

  logic [3:0]          w_fire;
  logic [3:0]          w_miss;
  logic [2:0]          w_miss_cnt;
  logic [DROP_W+2:0]   w_drop_sum;
  logic [DROP_W-1:0]   w_drop_sat;
  logic                w_addr_last;
  logic                w_tick;
  logic                w_entry_end;
  state_t              w_adv_state;
  logic [ADDR_W-1:0]   w_adv_addr;
  state_t              w_end_state;
  logic [ADDR_W-1:0]   w_end_addr;

  assign w_fire      = r_mask & lane_ready_i;
  assign w_miss      = r_mask & ~lane_ready_i;
  assign w_miss_cnt  = {2'b00, w_miss[0]} + {2'b00, w_miss[1]}
                     + {2'b00, w_miss[2]} + {2'b00, w_miss[3]};

  // Three spare bits above the counter catch any carry out; any carry means saturate.
  assign w_drop_sum  = {3'b000, r_drop} + {DROP_W'(0), w_miss_cnt};
  assign w_drop_sat  = (w_drop_sum[DROP_W+2:DROP_W] != 3'b000) ? '1 : w_drop_sum[DROP_W-1:0];

  assign w_tick      = sixteenth_i & ~pause_i;
  assign w_addr_last = &r_addr;
  assign w_entry_end = (rom_data_i == '0);

  // Stepping past the last address either ends playback or restarts the chart.
  assign w_adv_state = (w_addr_last && !LOOP_EN) ? S_DONE : S_FETCH;
  assign w_adv_addr  = w_addr_last ? (LOOP_EN ? '0 : r_addr) : r_addr + ADDR_W'(1);

  // End marker handling mirrors the overflow handling.
  assign w_end_state = LOOP_EN ? S_FETCH : S_DONE;
  assign w_end_addr  = LOOP_EN ? '0 : r_addr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_mask  <= '0;
      r_dur   <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_mask  <= w_mask_nxt;
      r_dur   <= w_dur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_mask_nxt  = r_mask;
    w_dur_nxt   = r_dur;
    w_cnt_nxt   = r_cnt;
    w_drop_nxt  = r_drop;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_drop_nxt  = '0;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_entry_end) begin
          w_state_nxt = w_end_state;
          w_addr_nxt  = w_end_addr;
        end else begin
          w_mask_nxt  = rom_data_i[3:0];
          w_dur_nxt   = rom_data_i[4 +: DUR_W];
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_drop_nxt = w_drop_sat;
        if (r_dur == '0) begin
          // Zero duration chains straight into the next entry (chords).
          w_state_nxt = w_adv_state;
          w_addr_nxt  = w_adv_addr;
        end else begin
          w_cnt_nxt   = r_dur;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Paused pulses are simply lost, not deferred.
        if (w_tick) begin
          if (r_cnt == DUR_W'(1)) begin
            w_state_nxt = w_adv_state;
            w_addr_nxt  = w_adv_addr;
          end else begin
            w_cnt_nxt = r_cnt - DUR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Stop overrides everything else; the drop count is kept for inspection.
    if (stop_i) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_drop_nxt  = r_drop;
    end
  end

  assign rom_addr_o = r_addr;
  assign rom_rd_o   = (r_state == S_FETCH);
  assign launch_o   = (r_state == S_LAUNCH) ? w_fire : 4'b0000;
  assign busy_o     = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign done_o     = (r_state == S_DONE);
  assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_chart_sequencer.sv
// tb/tb_chart_sequencer.sv - scoreboard bench for chart_sequencer with a launch-schedule reference model

module tb_chart_sequencer;

  localparam int NC   = 1024;
  localparam int SATV = 255;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i, stop_i, pause_i, sixteenth_i;
  logic [3:0]  lane_ready_i;
  logic [7:0]  rom_data_i;
  logic [7:0]  rom_addr_o;
  logic        rom_rd_o;
  logic [3:0]  launch_o;
  logic        busy_o, done_o;
  logic [7:0]  drop_cnt_o;

  chart_sequencer #(.ADDR_W(8), .DUR_W(4), .DROP_W(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .pause_i      (pause_i),
    .sixteenth_i  (sixteenth_i),
    .lane_ready_i (lane_ready_i),
    .rom_data_i   (rom_data_i),
    .rom_addr_o   (rom_addr_o),
    .rom_rd_o     (rom_rd_o),
    .launch_o     (launch_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Chart ROM: data appears the cycle after the read strobe.
  logic [7:0] chart [256];
  always @(posedge clk_i) if (rom_rd_o) rom_data_i <= chart[rom_addr_o];

  bit         six_a   [NC];
  bit         pause_a [NC];
  bit         stop_a  [NC];
  logic [3:0] ready_a [NC];

  typedef struct {
    int         cyc;
    logic [3:0] lanes;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int rel    = 0;
  bit mon_en = 1'b0;
  bit exp_done, exp_busy;
  int exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, rel);
    end
  endtask

  // Monitor: every launch the DUT presents is matched against the next scheduled one.
  always @(negedge clk_i) begin
    if (mon_en && launch_o !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", {28'd0, launch_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("launch_cycle", rel, e.cyc);
        chk("launch_lanes", {28'd0, launch_o}, {28'd0, e.lanes});
      end
    end
  end

  // Reference schedule: a launch at cycle L; zero duration -> next launch at L+3;
  // otherwise the dur-th unpaused sixteenth after L expires the entry and the next
  // launch follows 3 cycles after that pulse. Start in cycle s -> first launch s+3.
  task automatic build_model(input int len, input int s, input int stop_t);
    int  addr, L, nxt, cnt, drops, done_cyc, dur;
    bit  fin, done_r, stopped;
    logic [3:0] mask, lanes;
    addr = 0; L = s + 3; drops = 0; done_r = 0; done_cyc = 0; fin = 0;
    while (!fin) begin
      if (L > len - 1) begin
        fin = 1;
      end else if (stop_t >= 0 && L > stop_t) begin
        fin = 1;
      end else if (chart[addr] == 8'h00) begin
        done_r = 1; done_cyc = L; fin = 1;
      end else begin
        mask  = chart[addr][3:0];
        dur   = int'(chart[addr][7:4]);
        lanes = mask & ready_a[L];
        if (lanes != 4'b0000) exp_q.push_back('{cyc: L, lanes: lanes});
        if (L <= len - 2 && !(stop_t >= 0 && L >= stop_t)) begin
          drops = drops + $countones(mask & ~ready_a[L]);
          if (drops > SATV) drops = SATV;
        end
        nxt = -1;
        if (dur == 0) begin
          nxt = L + 3;
        end else begin
          cnt = 0;
          for (int c = L + 1; c < len && nxt < 0; c++) begin
            if (six_a[c] && !pause_a[c]) begin
              cnt++;
              if (cnt == dur) nxt = c + 3;
            end
          end
        end
        if (nxt < 0) begin
          fin = 1;
        end else if (addr == 255) begin
          done_r = 1; done_cyc = nxt - 2; fin = 1;
        end else begin
          addr++;
          L = nxt;
        end
      end
    end
    stopped  = (stop_t >= 0) && (stop_t + 1 <= len - 1);
    exp_done = !stopped && done_r && (done_cyc <= len - 1);
    exp_busy = !stopped && !exp_done;
    exp_drop = drops;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NC; i++) begin
      six_a[i] = 0; pause_a[i] = 0; stop_a[i] = 0; ready_a[i] = 4'hF;
    end
    for (int i = 0; i < 256; i++) chart[i] = 8'h00;
  endtask

  task automatic run_scn(input int len, input int s, input int stop_t);
    exp_q.delete();
    build_model(len, s, stop_t);
    mon_en = 1'b1;
    for (int r = 0; r < len; r++) begin
      @(posedge clk_i); #1;
      rel          = r;
      start_i      = (r == s);
      sixteenth_i  = six_a[r];
      pause_i      = pause_a[r];
      lane_ready_i = ready_a[r];
      stop_i       = stop_a[r];
    end
    @(negedge clk_i); #1;
    chk("pending_launches", exp_q.size(), 32'd0);
    chk("done", {31'd0, done_o}, {31'd0, exp_done});
    chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
    chk("drop_cnt", {24'd0, drop_cnt_o}, exp_drop);
    mon_en = 1'b0;
  endtask

  task automatic cleanup();
    @(posedge clk_i); #1;
    start_i = 0; sixteenth_i = 0; pause_i = 0; stop_i = 1;
    @(posedge clk_i); #1;
    stop_i = 0;
    @(negedge clk_i);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_launch", {28'd0, launch_o}, 32'd0);
    chk("idle_addr", {24'd0, rom_addr_o}, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] d4, m4;

    reset_i = 1; start_i = 0; stop_i = 0; pause_i = 0; sixteenth_i = 0; lane_ready_i = 4'hF;
    clear_stim();
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_launch", {28'd0, launch_o}, 32'd0);
    chk("rst_rd", {31'd0, rom_rd_o}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 0;

    // Two-entry chart paced every 10 cycles.
    clear_stim();
    chart[0] = 8'h21; chart[1] = 8'h18;
    for (int r = 10; r < NC; r += 10) six_a[r] = 1;
    run_scn(60, 2, -1);
    cleanup();

    // Chord: zero duration chains the next entry 3 cycles later.
    clear_stim();
    chart[0] = 8'h03; chart[1] = 8'h14;
    for (int r = 10; r < NC; r += 10) six_a[r] = 1;
    run_scn(40, 2, -1);
    cleanup();

    // Pause held across two pulses of a dur=3 entry.
    clear_stim();
    chart[0] = 8'h31; chart[1] = 8'h12;
    for (int r = 8; r < NC; r += 8) six_a[r] = 1;
    for (int r = 7; r <= 17; r++) pause_a[r] = 1;
    run_scn(80, 2, -1);
    cleanup();

    // Stop coinciding with the expiring sixteenth in WAIT.
    clear_stim();
    chart[0] = 8'h21; chart[1] = 8'h13;
    for (int r = 10; r < NC; r += 10) six_a[r] = 1;
    stop_a[20] = 1;
    run_scn(40, 2, 20);
    cleanup();

    // Full 256-entry chart: drop saturation and address-end termination.
    clear_stim();
    for (int i = 0; i < 256; i++) chart[i] = 8'h0F;
    for (int r = 0; r < NC; r++) ready_a[r] = 4'b1010;
    run_scn(800, 2, -1);
    cleanup();

    // Randomized charts and stimulus.
    for (int k = 0; k < 8; k++) begin
      clear_stim();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        d4 = 4'($urandom_range(0, 3));
        m4 = 4'($urandom_range(0, 15));
        chart[i] = {d4, m4};
        if (chart[i] == 8'h00) chart[i] = 8'h01;
      end
      for (int r = 0; r < NC; r++) begin
        six_a[r]   = ($urandom_range(0, 3) == 0);
        pause_a[r] = ($urandom_range(0, 4) == 0);
        ready_a[r] = 4'($urandom_range(0, 15));
      end
      run_scn(400, $urandom_range(1, 5), -1);
      cleanup();
    end

    // Asynchronous reset while waiting mid-chart.
    clear_stim();
    chart[0] = 8'h03; chart[1] = 8'h64;
    for (int r = 0; r < NC; r++) ready_a[r] = 4'b0001;
    run_scn(20, 2, -1);
    chk("pre_reset_addr", {24'd0, rom_addr_o}, 32'd1);
    @(negedge clk_i); #1;
    reset_i = 1;
    #1;
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("async_rst_addr", {24'd0, rom_addr_o}, 32'd0);
    chk("async_rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    chk("async_rst_done", {31'd0, done_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 0;

    // Playback resumes normally after reset.
    clear_stim();
    chart[0] = 8'h21; chart[1] = 8'h18;
    for (int r = 10; r < NC; r += 10) six_a[r] = 1;
    run_scn(60, 2, -1);
    cleanup();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
